// File: rtl/ysyx_22040386_mwreg_pkg.sv
// Shared constants and the MEM->WB write-back bundle layout.
package ysyx_22040386_mwreg_pkg;

    localparam int DATA_W  = 64;
    localparam int RADDR_W = 5;
    localparam int INST_W  = 32;

    // Write-back bundle carried from MEM to WB (trace fields first).
    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [INST_W-1:0]  inst;
        logic [DATA_W-1:0]  reg_wr_data;
        logic               RegWrite;
        logic [RADDR_W-1:0] reg_wr_addr;
        logic               csr_reg_write;
        logic [DATA_W-1:0]  csr_r_data;
    } mw_bundle_t;

endpackage

// File: rtl/ysyx_22040386_mwreg_skid2.sv
// Generic 2-entry valid/ready skid buffer: a head (main) entry that drives
// the outputs and one skid entry that absorbs the bundle arriving in the
// cycle downstream stalls. o_ready is a flop, so there is no ready path
// from downstream to upstream.
module ysyx_22040386_skid2 #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_main_v;
    logic         r_skid_v;
    logic         r_ready;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         w_accept;
    logic         w_deq;

    assign w_accept = i_valid && r_ready;
    assign w_deq    = r_main_v && i_ready;
    assign o_ready  = r_ready;
    assign o_valid  = r_main_v;
    assign o_data   = r_main;

    // Occupancy state machine: empty / main only / main + skid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_ready  <= 1'b1;
            r_main   <= '0;
            r_skid   <= '0;
        end else if (i_flush) begin
            // Data is left in place; it is don't-care once invalid.
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_ready  <= 1'b1;
        end else if (!r_main_v) begin
            if (w_accept) begin
                r_main   <= i_data;
                r_main_v <= 1'b1;
            end
        end else if (!r_skid_v) begin
            if (w_accept && w_deq) begin
                r_main <= i_data;
            end else if (w_accept) begin
                r_skid   <= i_data;
                r_skid_v <= 1'b1;
                r_ready  <= 1'b0;
            end else if (w_deq) begin
                r_main_v <= 1'b0;
            end
        end else if (w_deq) begin
            r_main   <= r_skid;
            r_skid_v <= 1'b0;
            r_ready  <= 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22040386_mwreg.sv
// MEM->WB pipeline register built on a 2-entry skid buffer. Adds the x0
// write suppression, the hazard-unit forwarding tap and a retire counter.
// Optional trace/difftest commit outputs: define YSYX_22040386_MW_COMMIT_EN.
module ysyx_22040386_mwreg
    import ysyx_22040386_mwreg_pkg::INST_W;
#(
    parameter int DATA_W  = 64,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 64
) (
    input  logic               i_MW_clk,
    input  logic               i_MW_rst,
    input  logic               i_MW_flush,
    input  logic               i_MW_valid,
    output logic               o_MW_ready,
    input  logic [DATA_W-1:0]  i_MW_pc,
    input  logic [INST_W-1:0]  i_MW_inst,
    input  logic [DATA_W-1:0]  i_MW_reg_wr_data,
    input  logic               i_MW_RegWrite,
    input  logic [RADDR_W-1:0] i_MW_reg_wr_addr,
    input  logic               i_MW_csr_reg_write,
    input  logic [DATA_W-1:0]  i_MW_csr_r_data,
    output logic               o_MW_valid,
    input  logic               i_MW_ready,
    output logic [DATA_W-1:0]  o_MW_pc,
    output logic [INST_W-1:0]  o_MW_inst,
    output logic [DATA_W-1:0]  o_MW_reg_wr_data,
    output logic               o_MW_RegWrite,
    output logic [RADDR_W-1:0] o_MW_reg_wr_addr,
    output logic               o_MW_csr_reg_write,
    output logic [DATA_W-1:0]  o_MW_csr_r_data,
    output logic               o_MW_fwd_valid,
    output logic [RADDR_W-1:0] o_MW_fwd_addr,
    output logic [DATA_W-1:0]  o_MW_fwd_data,
    output logic [CNT_W-1:0]   o_MW_retire_cnt
`ifdef YSYX_22040386_MW_COMMIT_EN
    ,
    output logic               o_MW_commit,
    output logic [DATA_W-1:0]  o_MW_commit_pc,
    output logic [INST_W-1:0]  o_MW_commit_inst
`endif
);

    localparam int PW = 3*DATA_W + INST_W + RADDR_W + 2;

    logic [PW-1:0]    w_in;
    logic [PW-1:0]    w_head;
    logic             w_regwrite;
    logic             w_deq;
    logic [CNT_W-1:0] r_retire_cnt;

    // Writes to x0 are dropped at capture so every consumer sees RegWrite=0.
    assign w_regwrite = i_MW_RegWrite && (i_MW_reg_wr_addr != '0);
    assign w_in = {i_MW_pc, i_MW_inst, i_MW_reg_wr_data, w_regwrite,
                   i_MW_reg_wr_addr, i_MW_csr_reg_write, i_MW_csr_r_data};

    ysyx_22040386_skid2 #(.W(PW)) u_skid (
        .i_clk   (i_MW_clk),
        .i_rst   (i_MW_rst),
        .i_flush (i_MW_flush),
        .i_valid (i_MW_valid),
        .o_ready (o_MW_ready),
        .i_data  (w_in),
        .o_valid (o_MW_valid),
        .i_ready (i_MW_ready),
        .o_data  (w_head)
    );

    assign {o_MW_pc, o_MW_inst, o_MW_reg_wr_data, o_MW_RegWrite,
            o_MW_reg_wr_addr, o_MW_csr_reg_write, o_MW_csr_r_data} = w_head;

    assign o_MW_fwd_valid = o_MW_valid && o_MW_RegWrite;
    assign o_MW_fwd_addr  = o_MW_reg_wr_addr;
    assign o_MW_fwd_data  = o_MW_csr_reg_write ? o_MW_csr_r_data : o_MW_reg_wr_data;

    assign w_deq           = o_MW_valid && i_MW_ready;
    assign o_MW_retire_cnt = r_retire_cnt;

    // Retire counter: one per downstream handshake, including in a flush cycle.
    always_ff @(posedge i_MW_clk) begin
        if (i_MW_rst)
            r_retire_cnt <= '0;
        else if (w_deq)
            r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

`ifdef YSYX_22040386_MW_COMMIT_EN
    logic              r_commit;
    logic [DATA_W-1:0] r_commit_pc;
    logic [INST_W-1:0] r_commit_inst;

    assign o_MW_commit      = r_commit;
    assign o_MW_commit_pc   = r_commit_pc;
    assign o_MW_commit_inst = r_commit_inst;

    // Commit pulse and trace copy of the retiring head entry.
    always_ff @(posedge i_MW_clk) begin
        if (i_MW_rst) begin
            r_commit      <= 1'b0;
            r_commit_pc   <= '0;
            r_commit_inst <= '0;
        end else begin
            r_commit <= w_deq;
            if (w_deq) begin
                r_commit_pc   <= o_MW_pc;
                r_commit_inst <= o_MW_inst;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040386_mwreg.sv
// Scoreboard bench for the MEM->WB register: the driver pushes the expected
// head bundle when an upstream handshake happens; a monitor pops and
// compares on every downstream handshake.
module tb_ysyx_22040386_mwreg;
    import ysyx_22040386_mwreg_pkg::*;

    logic               clk = 1'b0;
    logic               rst, flush, in_valid, out_ready;
    logic               o_ready, o_valid;
    logic [DATA_W-1:0]  i_pc, i_data, i_cd;
    logic [INST_W-1:0]  i_inst;
    logic               i_rw, i_csr;
    logic [RADDR_W-1:0] i_addr;
    logic [DATA_W-1:0]  o_pc, o_data, o_cd, o_fdata;
    logic [INST_W-1:0]  o_inst;
    logic               o_rw, o_csr, o_fvalid;
    logic [RADDR_W-1:0] o_addr, o_faddr;
    logic [63:0]        o_cnt;
`ifdef YSYX_22040386_MW_COMMIT_EN
    logic               o_commit;
    logic [DATA_W-1:0]  o_commit_pc;
    logic [INST_W-1:0]  o_commit_inst;
`endif

    int total = 0;
    int bad   = 0;
    mw_bundle_t q[$];

    always #5 clk = ~clk;

    ysyx_22040386_mwreg dut (
        .i_MW_clk(clk), .i_MW_rst(rst), .i_MW_flush(flush),
        .i_MW_valid(in_valid), .o_MW_ready(o_ready),
        .i_MW_pc(i_pc), .i_MW_inst(i_inst), .i_MW_reg_wr_data(i_data),
        .i_MW_RegWrite(i_rw), .i_MW_reg_wr_addr(i_addr),
        .i_MW_csr_reg_write(i_csr), .i_MW_csr_r_data(i_cd),
        .o_MW_valid(o_valid), .i_MW_ready(out_ready),
        .o_MW_pc(o_pc), .o_MW_inst(o_inst), .o_MW_reg_wr_data(o_data),
        .o_MW_RegWrite(o_rw), .o_MW_reg_wr_addr(o_addr),
        .o_MW_csr_reg_write(o_csr), .o_MW_csr_r_data(o_cd),
        .o_MW_fwd_valid(o_fvalid), .o_MW_fwd_addr(o_faddr),
        .o_MW_fwd_data(o_fdata), .o_MW_retire_cnt(o_cnt)
`ifdef YSYX_22040386_MW_COMMIT_EN
        , .o_MW_commit(o_commit), .o_MW_commit_pc(o_commit_pc),
        .o_MW_commit_inst(o_commit_inst)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Present one bundle and hold it until accepted; exp_rw is the RegWrite
    // the head entry must show (0 for x0 destinations).
    task automatic send(input logic [63:0] pc, input logic [31:0] inst,
                        input logic [63:0] d, input logic rw, input logic [4:0] a,
                        input logic csr, input logic [63:0] cd, input logic exp_rw);
        mw_bundle_t e;
        bit done = 0;
        i_pc = pc; i_inst = inst; i_data = d; i_rw = rw; i_addr = a;
        i_csr = csr; i_cd = cd; in_valid = 1'b1;
        e.pc = pc; e.inst = inst; e.reg_wr_data = d; e.RegWrite = exp_rw;
        e.reg_wr_addr = a; e.csr_reg_write = csr; e.csr_r_data = cd;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (o_ready) begin
                q.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every downstream handshake must match the oldest expected bundle.
    initial begin
        mw_bundle_t e;
        forever begin
            @(negedge clk);
            if (!rst && o_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_deq", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("pc", o_pc, e.pc);
                    chk("inst", {32'd0, o_inst}, {32'd0, e.inst});
                    chk("wr_data", o_data, e.reg_wr_data);
                    chk("RegWrite", {63'd0, o_rw}, {63'd0, e.RegWrite});
                    chk("wr_addr", {59'd0, o_addr}, {59'd0, e.reg_wr_addr});
                    chk("csr_wr", {63'd0, o_csr}, {63'd0, e.csr_reg_write});
                    chk("csr_data", o_cd, e.csr_r_data);
                    chk("fwd_valid", {63'd0, o_fvalid}, {63'd0, e.RegWrite});
                    chk("fwd_addr", {59'd0, o_faddr}, {59'd0, e.reg_wr_addr});
                    chk("fwd_data", o_fdata, e.csr_reg_write ? e.csr_r_data : e.reg_wr_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        i_pc = '0; i_inst = '0; i_data = '0; i_rw = 0; i_addr = '0; i_csr = 0; i_cd = '0;
        cyc(2);
        rst = 0;
        cyc(1);
        @(negedge clk);
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_cnt", o_cnt, 64'd0);
        chk("rst_pc", o_pc, 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_fwd_valid", {63'd0, o_fvalid}, 64'd0);
`ifdef YSYX_22040386_MW_COMMIT_EN
        chk("rst_commit", {63'd0, o_commit}, 64'd0);
`endif
        @(posedge clk); #1;

        // Streaming, one per cycle.
        out_ready = 1;
        for (int i = 0; i < 3; i++)
            send(64'h8000_0000 + 64'(4*i), 32'h13 + 32'(i), 64'h10 + 64'(i), 1, 5'd5, 0, 64'h0, 1);
        cyc(3);
        chk("stream_cnt", o_cnt, 64'd3);

        // Backpressure: A then B fill both entries.
        out_ready = 0;
        send(64'h100, 32'hA, 64'hA, 1, 5'd6, 0, 64'h0, 1);
        send(64'h104, 32'hB, 64'hB, 1, 5'd7, 0, 64'h0, 1);
        @(negedge clk);
        chk("bp_ready", {63'd0, o_ready}, 64'd0);
        chk("bp_valid", {63'd0, o_valid}, 64'd1);
        chk("bp_hold_a", o_data, 64'hA);
        cyc(2);
        @(negedge clk);
        chk("bp_hold_a2", o_data, 64'hA);
        @(posedge clk); #1;
        out_ready = 1;
        cyc(3);
        chk("bp_ready_back", {63'd0, o_ready}, 64'd1);
        chk("bp_cnt", o_cnt, 64'd5);
        chk("bp_empty", {63'd0, o_valid}, 64'd0);

        // x0 suppression and CSR forwarding.
        send(64'h200, 32'h1, 64'h55, 1, 5'd0, 0, 64'h0, 0);
        send(64'h204, 32'h2, 64'h99, 1, 5'd7, 1, 64'h1800, 1);
        cyc(3);
        chk("x0_csr_cnt", o_cnt, 64'd7);

        // Flush in S2 with a simultaneous incoming bundle.
        out_ready = 0;
        send(64'h300, 32'hC, 64'hC, 1, 5'd1, 0, 64'h0, 1);
        send(64'h304, 32'hD, 64'hD, 1, 5'd2, 0, 64'h0, 1);
        i_pc = 64'h308; i_data = 64'hE; in_valid = 1; flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        q.delete();
        @(negedge clk);
        chk("fl_valid", {63'd0, o_valid}, 64'd0);
        chk("fl_ready", {63'd0, o_ready}, 64'd1);
        chk("fl_cnt", o_cnt, 64'd7);
        @(posedge clk); #1;
        out_ready = 1;
        cyc(2);
        chk("fl_cnt2", o_cnt, 64'd7);

        // Flush with a deq and an accept in the same cycle.
        out_ready = 0;
        send(64'h400, 32'hF, 64'hF, 1, 5'd3, 0, 64'h0, 1);
        out_ready = 1; flush = 1; in_valid = 1; i_pc = 64'h404; i_data = 64'h2A;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("fldq_cnt", o_cnt, 64'd8);
        chk("fldq_valid", {63'd0, o_valid}, 64'd0);
        @(posedge clk); #1;

        // Reset during S2 with flush and backpressure.
        out_ready = 0;
        send(64'h500, 32'h7, 64'h77, 1, 5'd4, 0, 64'h0, 1);
        send(64'h504, 32'h8, 64'h88, 1, 5'd4, 1, 64'h66, 1);
        rst = 1; flush = 1; in_valid = 1;
        @(posedge clk); #1;
        rst = 0; flush = 0; in_valid = 0;
        q.delete();
        @(negedge clk);
        chk("rr_valid", {63'd0, o_valid}, 64'd0);
        chk("rr_ready", {63'd0, o_ready}, 64'd1);
        chk("rr_cnt", o_cnt, 64'd0);
        chk("rr_pc", o_pc, 64'd0);
        chk("rr_data", o_data, 64'd0);
        chk("rr_fwd_data", o_fdata, 64'd0);
        @(posedge clk); #1;

`ifdef YSYX_22040386_MW_COMMIT_EN
        out_ready = 1;
        send(64'h8000_0004, 32'h0000_0073, 64'h1, 1, 5'd9, 0, 64'h0, 1);
        @(posedge clk); #1;
        chk("commit_pulse", {63'd0, o_commit}, 64'd1);
        chk("commit_pc", o_commit_pc, 64'h8000_0004);
        chk("commit_inst", {32'd0, o_commit_inst}, 64'h73);
        @(posedge clk); #1;
        chk("commit_drop", {63'd0, o_commit}, 64'd0);
`endif

        cyc(2);
        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
